debouncer_bank: RTL and testbench

//   Parametrised N-channel debouncer for the parking-lot sensor and button inputs.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 116 +++++++++++
 rtl/debouncer_bank.sv | 36 +++
 tb/tb_debouncer_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and 12 MHz default timing for the pin debouncers.
// Defaults: 20 ms qualify window, 500 ms long-press hold.
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } deb_state_t;

  localparam int unsigned CLK_HZ            = 12_000_000;
  localparam int unsigned DEF_STABLE_CYCLES = CLK_HZ / 50;
  localparam int unsigned DEF_LONG_CYCLES   = CLK_HZ / 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, qualify FSM, registered rise/fall pulses.
// clean follows a steady input 2+STABLE_CYCLES edges later; no backpressure.
// DEBOUNCE_LONGPRESS_EN adds a saturating hold counter driving long_press.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1, sync2;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             clean_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE;
      count <= '0;
      clean <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      clean <= clean_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Entering QUALIFY already counts the first differing sample.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    clean_nxt = clean;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE: begin
        if (sync2 != clean) begin
          state_nxt = QUALIFY;
          count_nxt = CNT_W'(1);
        end else begin
          count_nxt = '0;
        end
      end
      QUALIFY: begin
        if (sync2 == clean) begin
          state_nxt = STABLE;
          count_nxt = '0;
        end else if (count == CNT_MAX) begin
          clean_nxt = sync2;
          rise_nxt  = sync2;
          fall_nxt  = ~sync2;
          state_nxt = STABLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE;
        count_nxt = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold;

  // Saturation at HOLD_MAX is what keeps long_press to one pulse per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!clean) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold       <= hold + 1'b1;
        long_press <= (hold == HOLD_MAX - 1'b1);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debouncer_bank.sv
// N_CH independent debounce lanes for raw sensor/button pins; per-lane latency
// 2+STABLE_CYCLES edges, no backpressure. DEBOUNCE_LONGPRESS_EN enables long_press.
module debouncer_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .RESET_VAL     (RESET_VAL)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .noisy      (noisy[i]),
      .clean      (clean[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Scoreboard bench for debouncer_bank: expected pulses are queued with their cycle
// when stimulus is driven and consumed by a monitor sampling 1 time unit after each edge.
module tb_debouncer_bank;

  localparam int SC = 8;
  localparam int LC = 32;
  localparam int LAT = 2 + SC;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] noisy;
  logic [3:0] clean, rise, fall, long_press;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    int ch;
    int at;
  } ev_t;
  ev_t exp_q[$];

  logic [3:0] mon_v;
  int         mon_hit;

  debouncer_bank #(
    .N_CH          (4),
    .STABLE_CYCLES (SC),
    .LONG_CYCLES   (LC),
    .RESET_VAL     (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .noisy      (noisy),
    .clean      (clean),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    return (k == 0) ? "rise" : (k == 1) ? "fall" : "long_press";
  endfunction

  task automatic expect_ev(input int k, input logic [3:0] m, input int at);
    for (int c = 0; c < 4; c++)
      if (m[c]) exp_q.push_back('{kind: k, ch: c, at: at});
  endtask

  task automatic drive(input logic [3:0] v, output int base);
    @(negedge clk);
    noisy = v;
    base  = cyc;
  endtask

  // Pulse monitor: every observed pulse must match a queued expectation exactly.
  initial forever begin
    @(posedge clk);
    #1;
    checks++;
    if ((rise & fall) !== 4'b0000) begin
      errors++;
      $display("FAIL rise_fall_overlap: rise=%b fall=%b, required disjoint", rise, fall);
    end
    for (int k = 0; k < 3; k++) begin
      mon_v = (k == 0) ? rise : (k == 1) ? fall : long_press;
      for (int c = 0; c < 4; c++) begin
        if (mon_v[c] !== 1'b0) begin
          mon_hit = -1;
          foreach (exp_q[j])
            if (mon_hit < 0 && exp_q[j].kind == k && exp_q[j].ch == c && exp_q[j].at == cyc)
              mon_hit = j;
          checks++;
          if (mon_hit < 0) begin
            errors++;
            $display("FAIL %s_unexpected: ch%0d value %b at cycle %0d, required 0",
                     kname(k), c, mon_v[c], cyc);
          end else begin
            exp_q.delete(mon_hit);
          end
        end
      end
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].at <= cyc) begin
        checks++;
        errors++;
        $display("FAIL %s_missing: ch%0d no pulse, required at cycle %0d",
                 kname(exp_q[j].kind), exp_q[j].ch, exp_q[j].at);
        exp_q.delete(j);
      end
    end
  end

  task automatic test_reset();
    int b;
    rst   = 1'b1;
    noisy = 4'h0;
    #1;
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL reset_clean: clean=%b required 0000", clean); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(4'hF, b);
    expect_ev(0, 4'hF, b + LAT);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL reset_pre_accept: clean=%b required 0000", clean); end
    @(negedge clk);
    checks++;
    if (clean !== 4'hF) begin errors++; $display("FAIL reset_accept: clean=%b required 1111", clean); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL async_reset_clean: clean=%b required 0000", clean); end
    checks++;
    if ({rise, fall, long_press} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset_pulses: rise=%b fall=%b long=%b required 0", rise, fall, long_press);
    end
    @(negedge clk);
    rst   = 1'b0;
    noisy = 4'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_step();
    int b;
    drive(4'h1, b);
    expect_ev(0, 4'h1, b + LAT);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL step_early: clean=%b required 0000", clean); end
    @(negedge clk);
    checks++;
    if (clean !== 4'h1) begin errors++; $display("FAIL step_rise: clean=%b required 0001", clean); end
    drive(4'h0, b);
    expect_ev(1, 4'h1, b + LAT);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL step_fall: clean=%b required 0000", clean); end
  endtask

  task automatic test_glitch();
    int b;
    drive(4'h2, b);
    repeat (4) @(negedge clk);
    drive(4'h0, b);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL glitch5_clean: clean=%b required 0000", clean); end
    drive(4'h2, b);
    repeat (6) @(negedge clk);
    drive(4'h0, b);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL glitch7_clean: clean=%b required 0000", clean); end
  endtask

  task automatic test_bounce();
    int b;
    logic [3:0] v;
    v = 4'h0;
    for (int i = 0; i < 6; i++) begin
      v = v ^ 4'h4;
      drive(v, b);
      repeat (2) @(negedge clk);
    end
    drive(4'h4, b);
    expect_ev(0, 4'h4, b + LAT);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL bounce_early: clean=%b required 0000", clean); end
    @(negedge clk);
    checks++;
    if (clean !== 4'h4) begin errors++; $display("FAIL bounce_settle: clean=%b required 0100", clean); end
    drive(4'h0, b);
    expect_ev(1, 4'h4, b + LAT);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL bounce_release: clean=%b required 0000", clean); end
  endtask

  task automatic test_parallel();
    int b;
    int b2;
    drive(4'hF, b);
    expect_ev(0, 4'hF, b + LAT);
`ifdef DEBOUNCE_LONGPRESS_EN
    expect_ev(2, 4'h7, b + LAT + LC);
`endif
    repeat (LAT) @(negedge clk);
    checks++;
    if (clean !== 4'hF) begin errors++; $display("FAIL parallel_rise: clean=%b required 1111", clean); end
    drive(4'h7, b2);
    expect_ev(1, 4'h8, b2 + LAT);
    repeat (40) @(negedge clk);
    checks++;
    if (clean !== 4'h7) begin errors++; $display("FAIL parallel_fall3: clean=%b required 0111", clean); end
    drive(4'h0, b);
    expect_ev(1, 4'h7, b + LAT);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL parallel_release: clean=%b required 0000", clean); end
  endtask

  task automatic test_long_press();
    int b;
    for (int p = 0; p < 2; p++) begin
      drive(4'h1, b);
      expect_ev(0, 4'h1, b + LAT);
`ifdef DEBOUNCE_LONGPRESS_EN
      expect_ev(2, 4'h1, b + LAT + LC);
`endif
      repeat (LAT + LC + 3 * LC * (1 - p) + 8) @(negedge clk);
      checks++;
      if (clean !== 4'h1) begin errors++; $display("FAIL long_hold%0d: clean=%b required 0001", p, clean); end
      drive(4'h0, b);
      expect_ev(1, 4'h1, b + LAT);
      repeat (LAT + 2) @(negedge clk);
      checks++;
      if (clean !== 4'h0) begin errors++; $display("FAIL long_release%0d: clean=%b required 0000", p, clean); end
    end
    // Abort a qualification midway (count == 4) with reset.
    drive(4'h1, b);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL abort_clean: clean=%b required 0000", clean); end
    @(negedge clk);
    rst   = 1'b0;
    noisy = 4'h0;
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (clean !== 4'h0) begin errors++; $display("FAIL abort_after: clean=%b required 0000", clean); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_parallel();
    test_long_press();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
